// File: rtl/quadrature_position_counter.sv
// Quadrature encoder decoder with per-input glitch filter, X1/X2/X4 decoding,
// wrapping position counter, index capture/auto-clear and a sticky illegal-transition flag.
module quadrature_position_counter #(
    parameter int COUNT_WIDTH = 32,
    parameter int FILTER_LEN  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   quadA_in,
    input  logic                   quadB_in,
    input  logic                   quadI_in,
    input  logic [1:0]             mode,
    input  logic                   clear_count,
    input  logic                   index_clear_en,
    output logic [COUNT_WIDTH-1:0] count,
    output logic [COUNT_WIDTH-1:0] index_count,
    output logic                   index_valid,
    output logic                   count_pulse,
    output logic                   direction,
    output logic                   error
);

    typedef enum logic [1:0] {
        MODE_X1     = 2'b00,
        MODE_X2     = 2'b01,
        MODE_X4     = 2'b10,
        MODE_X4_ALT = 2'b11
    } mode_t;

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);

    // Bit order for the per-input vectors: [0] = A, [1] = B, [2] = I.
    logic [2:0]    raw;
    logic [2:0]    filt;
    logic [2:0]    prev;
    logic [FW-1:0] fcnt [3];
    logic          init_pending;

    assign raw = {quadI_in, quadB_in, quadA_in};

    // Filter counters and filtered values; the init cycle loads them straight from the pins.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            filt         <= '0;
            prev         <= '0;
            init_pending <= 1'b1;
            for (int i = 0; i < 3; i++) begin
                fcnt[i] <= '0;
            end
        end else begin
            init_pending <= 1'b0;
            prev         <= init_pending ? raw : filt;
            for (int i = 0; i < 3; i++) begin
                if (init_pending) begin
                    filt[i] <= raw[i];
                    fcnt[i] <= '0;
                end else if (raw[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FILT_LAST) begin
                    filt[i] <= raw[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FW'(1);
                end
            end
        end
    end

    logic a_chg;
    logic b_chg;
    logic illegal;
    logic step_dir;
    logic step;
    logic i_rise;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        a_chg    = 1'b0;
        b_chg    = 1'b0;
        illegal  = 1'b0;
        step_dir = 1'b0;
        step     = 1'b0;
        i_rise   = 1'b0;
        if (!init_pending) begin
            a_chg    = filt[0] ^ prev[0];
            b_chg    = filt[1] ^ prev[1];
            illegal  = a_chg & b_chg;
            step_dir = filt[0] ^ prev[1];
            i_rise   = filt[2] & ~prev[2];
            case (mode_t'(mode))
                MODE_X1: step = a_chg & ~b_chg & (filt[0] == step_dir);
                MODE_X2: step = a_chg & ~b_chg;
                default: step = a_chg ^ b_chg;
            endcase
        end
    end

    // Count priority: clear request, then index auto-clear, then the decoded step.
    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            index_count <= '0;
            index_valid <= 1'b0;
            count_pulse <= 1'b0;
            direction   <= 1'b0;
            error       <= 1'b0;
        end else begin
            count_pulse <= step;
            index_valid <= i_rise;
            if (step) begin
                direction <= step_dir;
            end
            if (i_rise) begin
                index_count <= count;
            end
            if (clear_count) begin
                count <= '0;
            end else if (i_rise && index_clear_en) begin
                count <= '0;
            end else if (step) begin
                count <= step_dir ? count + COUNT_WIDTH'(1) : count - COUNT_WIDTH'(1);
            end
            if (clear_count) begin
                error <= 1'b0;
            end else if (illegal) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_quadrature_position_counter.sv
// Scoreboard bench: stimulus pushes hand-derived events, a negedge monitor pops and compares them.
module tb_quadrature_position_counter;

    localparam int CW = 16;
    localparam int FL = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          qa = 1'b0;
    logic          qb = 1'b0;
    logic          qi = 1'b0;
    logic [1:0]    mode = 2'b10;
    logic          clear_count = 1'b0;
    logic          index_clear_en = 1'b0;
    logic [CW-1:0] count;
    logic [CW-1:0] index_count;
    logic          index_valid;
    logic          count_pulse;
    logic          direction;
    logic          error;

    quadrature_position_counter #(.COUNT_WIDTH(CW), .FILTER_LEN(FL)) dut (
        .clk            (clk),
        .reset          (reset),
        .quadA_in       (qa),
        .quadB_in       (qb),
        .quadI_in       (qi),
        .mode           (mode),
        .clear_count    (clear_count),
        .index_clear_en (index_clear_en),
        .count          (count),
        .index_count    (index_count),
        .index_valid    (index_valid),
        .count_pulse    (count_pulse),
        .direction      (direction),
        .error          (error)
    );

    typedef struct {
        logic          cp;
        logic          iv;
        logic [CW-1:0] cnt;
        logic          dir;
        logic [CW-1:0] idx;
    } exp_t;

    exp_t          sbq[$];
    int            checks = 0;
    int            failures = 0;
    int            pulses_seen = 0;
    logic [CW-1:0] exp_count = '0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one A/B/I state; a nonzero delta means a counted edge is expected.
    task automatic drive(input logic a, input logic b, input logic i, input int delta, input int hold);
        exp_t e;
        qa = a;
        qb = b;
        qi = i;
        if (delta != 0) begin
            exp_count = exp_count + CW'(delta);
            e.cp  = 1'b1;
            e.iv  = 1'b0;
            e.cnt = exp_count;
            e.dir = (delta > 0);
            e.idx = '0;
            sbq.push_back(e);
        end
        tick(hold);
    endtask

    // Full A/B cycles starting from 00; d0..d3 are the hand-derived per-edge count deltas.
    task automatic run_cycles(input bit fwd, input int n, input int d0, input int d1, input int d2, input int d3);
        logic [1:0] st [4];
        int         d [4];
        d = '{d0, d1, d2, d3};
        if (fwd) st = '{2'b10, 2'b11, 2'b01, 2'b00};
        else     st = '{2'b01, 2'b11, 2'b10, 2'b00};
        for (int c = 0; c < n; c++) begin
            for (int k = 0; k < 4; k++) begin
                drive(st[k][1], st[k][0], 1'b0, d[k], 8);
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (count_pulse || index_valid) begin
            if (count_pulse) pulses_seen++;
            check("event_expected", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("mon_count_pulse", 32'(count_pulse), 32'(e.cp));
                check("mon_index_valid", 32'(index_valid), 32'(e.iv));
                check("mon_count", 32'(count), 32'(e.cnt));
                if (e.cp) check("mon_direction", 32'(direction), 32'(e.dir));
                if (e.iv) check("mon_index_count", 32'(index_count), 32'(e.idx));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   p0;
        exp_t e;

        // Reset values
        reset = 1'b1;
        tick(3);
        check("rst_count", 32'(count), 32'h0);
        check("rst_index_count", 32'(index_count), 32'h0);
        check("rst_index_valid", 32'(index_valid), 32'h0);
        check("rst_count_pulse", 32'(count_pulse), 32'h0);
        check("rst_direction", 32'(direction), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        reset = 1'b0;
        tick(2);

        // X4: 10 forward cycles
        mode = 2'b10;
        p0 = pulses_seen;
        run_cycles(1'b1, 10, 1, 1, 1, 1);
        check("x4_count", 32'(count), 32'd40);
        check("x4_pulses", 32'(pulses_seen - p0), 32'd40);
        check("x4_direction", 32'(direction), 32'd1);
        check("x4_error", 32'(error), 32'd0);

        // X1 then X2, forward then reverse
        clear_count = 1'b1;
        tick(1);
        clear_count = 1'b0;
        exp_count = '0;
        check("clear_count", 32'(count), 32'h0);
        mode = 2'b00;
        run_cycles(1'b1, 3, 1, 0, 0, 0);
        check("x1_fwd", 32'(count), 32'd3);
        run_cycles(1'b0, 3, 0, 0, 0, -1);
        check("x1_rev", 32'(count), 32'd0);
        mode = 2'b01;
        run_cycles(1'b1, 3, 1, 0, 1, 0);
        check("x2_fwd", 32'(count), 32'd6);
        run_cycles(1'b0, 3, 0, -1, 0, -1);
        check("x2_rev", 32'(count), 32'd0);

        // Glitch filter: 3 clocks rejected, 4 clocks accepted with n+4 latency
        mode = 2'b10;
        qa = 1'b1;
        tick(3);
        qa = 1'b0;
        tick(8);
        check("glitch3_count", 32'(count), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1, 4);
        check("glitch4_no_pulse_n3", 32'(count_pulse), 32'd0);
        drive(1'b0, 1'b0, 1'b0, -1, 1);
        check("glitch4_pulse_n4", 32'(count_pulse), 32'd1);
        check("glitch4_count_n4", 32'(count), 32'd1);
        tick(8);
        check("glitch4_back", 32'(count), 32'd0);

        // Wrap-around
        drive(1'b0, 1'b1, 1'b0, -1, 8);
        check("wrap_down", 32'(count), 32'h0000FFFF);
        drive(1'b0, 1'b0, 1'b0, 1, 8);
        check("wrap_up", 32'(count), 32'h0);

        // Index capture with auto-clear, coincident with a forward edge
        run_cycles(1'b1, 30, 1, 1, 1, 1);
        drive(1'b1, 1'b0, 1'b0, 1, 8);
        drive(1'b1, 1'b1, 1'b0, 1, 8);
        drive(1'b0, 1'b1, 1'b0, 1, 8);
        check("pre_index_count", 32'(count), 32'd123);
        index_clear_en = 1'b1;
        e.cp  = 1'b1;
        e.iv  = 1'b1;
        e.cnt = '0;
        e.dir = 1'b1;
        e.idx = CW'(123);
        sbq.push_back(e);
        exp_count = '0;
        qa = 1'b0;
        qb = 1'b0;
        qi = 1'b1;
        tick(5);
        check("index_valid_hi", 32'(index_valid), 32'd1);
        tick(1);
        check("index_valid_lo", 32'(index_valid), 32'd0);
        check("index_cleared_count", 32'(count), 32'd0);
        check("index_count_held", 32'(index_count), 32'd123);
        tick(4);
        qi = 1'b0;
        tick(8);
        index_clear_en = 1'b0;

        // Illegal transition, clear, then reset with inputs at 11
        drive(1'b1, 1'b0, 1'b0, 1, 8);
        qa = 1'b0;
        qb = 1'b1;
        tick(8);
        check("illegal_error", 32'(error), 32'd1);
        check("illegal_count", 32'(count), 32'd1);
        clear_count = 1'b1;
        tick(1);
        clear_count = 1'b0;
        exp_count = '0;
        check("clear_after_err_count", 32'(count), 32'd0);
        check("clear_after_err_error", 32'(error), 32'd0);
        qa = 1'b1;
        qb = 1'b1;
        reset = 1'b1;
        tick(2);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_pulse", 32'(count_pulse), 32'd0);
        reset = 1'b0;
        tick(10);
        check("post_init_count", 32'(count), 32'd0);
        check("post_init_error", 32'(error), 32'd0);

        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/quadrature_position_counter.md
# quadrature_position_counter

Parametrised successor to the X4-only quadrature decoder. It adds a per-input glitch filter, selectable X1/X2/X4 decoding, an integrated wrapping position counter, index-pulse position capture with optional auto-clear, and a sticky illegal-transition flag. It sits between the input synchronisers and the register/bus interface, one instance per encoder channel, and replaces the separate decoder-plus-counter pair.

## Interface
- `COUNT_WIDTH`, 32: width of position and index-capture registers (two's complement, ≥8).
- `FILTER_LEN`, 4: consecutive clocks an input must differ from its filtered value before it is accepted (≥1; 1 = no filtering).
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  reset, synchronous, active-high.
- `quadA_in`, `quadB_in`, `quadI_in`  in  1 each  synchronised encoder A, B and index.
- `mode`  in  2  00 = X1, 01 = X2, 10/11 = X4.
- `clear_count`  in  1  one-cycle request: count ← 0, error ← 0.
- `index_clear_en`  in  1  1 = a filtered index rising edge also zeroes count.
- `count`  out  COUNT_WIDTH  signed position.
- `index_count`  out  COUNT_WIDTH  count captured at the last index rising edge.
- `index_valid`  out  1  one-cycle pulse when `index_count` is updated.
- `count_pulse`  out  1  one-cycle pulse per counted edge.
- `direction`  out  1  direction of the last counted edge (1 = forward, A leads B).
- `error`  out  1  sticky: illegal transition, i.e. filtered A and B changed on the same edge.

## Operation
- **Filter** (A, B and I independently):
  - Per-input counter increments while raw ≠ filtered and clears when raw = filtered.
  - Filtered value takes the raw value on the edge at which raw has been sampled different on FILTER_LEN consecutive edges.
- **Init cycle**: first edge after reset deasserts loads filtered and delayed registers directly from the raw inputs. Nothing is counted, `error` is not set, and no index edge is seen.
- **Decode**: compare filtered {A,B} with the delayed copy.
  - Forward sequence: 00→10→11→01→00.
  - Edge direction = A_new XOR B_old.
- **Counted edges per mode**:
  - X4: every single-bit change.
  - X2: A changes only (both polarities).
  - X1: A rising while forward (+1); A falling while reverse (−1).
  - Result: a back-and-forth across one edge nets 0 in every mode.
- **Illegal transition**: A and B both change on one edge → `error` ← 1, no count, no `count_pulse`.
- **Counter**: ±1 per counted edge, modulo 2^COUNT_WIDTH (FFFF…+1 = 0, 0−1 = all ones).
- **Index**: filtered I rising edge → `index_count` ← pre-update `count`, `index_valid` pulses.
  - If `index_clear_en` = 1, count ← 0.
- **Count priority**: reset > `clear_count` > index clear > step. A step on the same edge as a clear is discarded, but `count_pulse` and `direction` still report it.
- **Mode changes**: take effect on the next edge. `count` is never altered by a mode change.

## Timing
- **Reset values**: every output = 0. Filter counters, filtered and delayed registers = 0.
- **Latency from a raw change** (first sampled at edge n):
  - Filtered value changes at edge n+FILTER_LEN−1.
  - `count`, `count_pulse`, `direction`, `error`, `index_count` and `index_valid` update at edge n+FILTER_LEN.
- **Alignment**: `count_pulse` and `index_valid` are high for exactly one cycle, aligned with the new `count` value.
- **Clear**: `clear_count` sampled high at edge m → count = 0 and error = 0 after edge m.
- **Throughput**: at most one counted edge per FILTER_LEN clocks per input. Faster input is rejected by the filter, not miscounted.
- **Reset mid-motion**: all state cleared, then init cycle. No spurious count or error, regardless of input levels.

## Test plan
1. COUNT_WIDTH=16, FILTER_LEN=4, X4; 10 forward A/B cycles, 8 clocks per state -> count=40, 40 `count_pulse`s, direction=1, error=0.
2. X1: 3 cycles forward then 3 reverse -> count 3 then 0. Repeat in X2 -> count 6 then 0.
3. Glitch on A, 3 clocks wide -> no count change. Same glitch 4 clocks wide -> count_pulse asserted at edge n+4.
4. count=0, one reverse X4 edge -> 16'hFFFF; one forward edge -> 16'h0000.
5. count=123, index_clear_en=1, index rising coincident with a forward edge -> index_count=123, index_valid 1 cycle, count=0.
6. A and B toggled on the same clock -> error=1, count unchanged; then clear_count -> error=0, count=0. Then reset asserted with inputs at 11 -> after init cycle count=0, error=0.
